neuron_array_seq: RTL and testbench
===================================

// Module: neuron_array_seq
// PURPOSE
// Parametrised host-side sequencer for the neuron array: word-serial configuration load, bounded run, spike-probe tracking and handshaked readout.
// Drives per-neuron write strobes and the array run enable; consumes the spike stream produced by the mux network.
// Supports a programmable active neuron count, a cycle-bounded run length and an arbitrary readout word width.
// Host input and output both use valid/ready handshakes.
// PARAMETERS
// FP_DATA_WIDTH    16   host input word width; also Vmem/mu width; must be >= NEURON_ID_WIDTH+2
// TEN_DATA_WIDTH   2    spike/Q value width
// NUM_NEURON       512  physical neurons in array
// NEURON_ID_WIDTH  9    clog2(NUM_NEURON)
// OUT_WIDTH        16   readout word width, 1..NUM_NEURON
// PORTS
// clk           in   1                clock, all logic posedge
// reset         in   1                synchronous, active-high reset
// in_valid      in   1                host word valid
// in_ready      out  1                host word accepted when in_valid&in_ready
// in_data       in   FP_DATA_WIDTH    command or payload word
// out_valid     out  1                readout word valid
// out_ready     in   1                host takes readout word
// out_data      out  OUT_WIDTH        readout word
// arr_wr_en     out  1                one-cycle write strobe to neuron arr_wr_idx
// arr_wr_field  out  2                0=Vmem 1=mu 2=neuronI 3=Q
// arr_wr_idx    out  NEURON_ID_WIDTH  target neuron
// arr_wr_data   out  FP_DATA_WIDTH    payload (low bits used for neuronI/Q)
// arr_run       out  1                array/network enable (en_spike)
// spike_valid   in   1                networkDone: spike_id/spike_val valid
// spike_id      in   NEURON_ID_WIDTH  spiking neuron
// spike_val     in   TEN_DATA_WIDTH   spike value; 0 = no spike
// busy          out  1                state != IDLE
// run_done      out  1                one-cycle pulse on RUN exit
// BEHAVIOUR
// Reset: state=IDLE; active_cnt=NUM_NEURON; states vector all 1; all outputs 0 except in_ready=1.
// FSM: IDLE, LOAD, RUN, READOUT. in_ready=1 in IDLE/LOAD, 0 in RUN/READOUT.
// IDLE opcode = in_data[FP_DATA_WIDTH-1 -: 2], acted on at accept:
//   00 SET_ACTIVE: active_cnt <= in_data[NEURON_ID_WIDTH-1:0]+1 (range 1..NUM_NEURON); stay IDLE.
//   01 LOAD: states <= all 1; word_cnt <= 0; -> LOAD.
//   10 RUN: run_left <= in_data[FP_DATA_WIDTH-3:0]. If 0: -> READOUT, run_done pulses next cycle, arr_run never asserts. Otherwise -> RUN.
//   11 READ: -> READOUT, no run.
// LOAD consumes exactly 4*active_cnt words; neuron n receives words 4n..4n+3 as Vmem, mu, neuronI, Q.
// LOAD write timing: arr_wr_* are registered and assert one cycle after each accept.
//   arr_wr_idx = word_cnt>>2; arr_wr_field = word_cnt[1:0].
// After the last accept, -> IDLE. in_valid gaps stall LOAD without side effects.
// RUN: arr_run=1 for exactly run_left cycles, starting the cycle after the RUN accept; run_left decrements each cycle.
// RUN exit: when run_left==1, next state is READOUT; run_done pulses on the first READOUT cycle.
// Spike probe: while state==RUN, each spike_valid with spike_val!=0 and spike_id<active_cnt toggles states[spike_id].
//   Spikes with spike_val==0, spike_id>=active_cnt, or arriving outside RUN are ignored.
//   A spike on the final RUN cycle is counted.
// READOUT: words = ceil(active_cnt/OUT_WIDTH).
//   Word k = states[k*OUT_WIDTH +: OUT_WIDTH], with bit positions >= active_cnt forced to 0.
//   out_valid=1 and out_data held stable until out_ready; word index advances on handshake.
//   Handshake on the last word -> IDLE.
// The states vector persists across RUN/READ; it is re-initialised only by reset or a LOAD command.
// Reset asserted mid-LOAD/RUN/READOUT: immediate return to the reset values; no partial write strobe is issued after reset.
// TESTING
// T1 reset: hold reset 3 cycles -> busy=0, out_valid=0, arr_run=0, arr_wr_en=0, in_ready=1.
// T2 SET_ACTIVE 0x0003 then LOAD with 16 words 0x100..0x10F:
//   -> 16 arr_wr_en pulses; idx 0..3; fields cycle 0,1,2,3; data matches; then IDLE.
// T3 RUN 0x8005 with spikes (id2,val1), (id2,val2), (id1,val0), (id7,val1)
//   -> arr_run high exactly 5 cycles; run_done once; readout 1 word = 0x000F (id2 toggled twice; id1 val0 and id7 out of range ignored).
// T4 SET_ACTIVE 39 (active_cnt=40), OUT_WIDTH=16, READ
//   -> 3 words 0xFFFF, 0xFFFF, 0x00FF. out_ready held low 4 cycles on word 1 -> out_data stable, no skip.
// T5 RUN 0x8000 -> no arr_run, run_done pulse, readout follows; spike_valid asserted in IDLE/READOUT changes nothing.
// T6 reset asserted during LOAD word 5 -> IDLE; next LOAD restarts at idx 0, field 0.

Source files
------------

// File: rtl/neuron_array_seq.sv
// Host-side sequencer for the neuron array: config load, bounded run,
// spike-probe state tracking and handshaked readout.
module neuron_array_seq #(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9,
  parameter int OUT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FP_DATA_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       arr_wr_en,
  output logic [1:0]                 arr_wr_field,
  output logic [NEURON_ID_WIDTH-1:0] arr_wr_idx,
  output logic [FP_DATA_WIDTH-1:0]   arr_wr_data,
  output logic                       arr_run,
  input  logic                       spike_valid,
  input  logic [NEURON_ID_WIDTH-1:0] spike_id,
  input  logic [TEN_DATA_WIDTH-1:0]  spike_val,
  output logic                       busy,
  output logic                       run_done
);

  localparam int AW    = NEURON_ID_WIDTH + 1;
  localparam int WW    = NEURON_ID_WIDTH + 3;
  localparam int RW    = FP_DATA_WIDTH - 2;
  localparam int NWORD = (NUM_NEURON + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PW    = NWORD * OUT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [AW-1:0]           r_active;
  logic [NUM_NEURON-1:0]   r_states;
  logic [WW-1:0]           r_word_cnt;
  logic [RW-1:0]           r_run_left;
  logic [AW-1:0]           r_rd_idx;
  logic                    r_wr_en;
  logic [1:0]              r_wr_field;
  logic [NEURON_ID_WIDTH-1:0] r_wr_idx;
  logic [FP_DATA_WIDTH-1:0] r_wr_data;
  logic                    r_run_done;

  logic                    w_acc;
  logic [1:0]              w_op;
  logic                    w_load_last;
  logic                    w_done;
  logic                    w_spk_hit;
  logic                    w_rd_last;
  logic [31:0]             w_rd_end;
  logic [NUM_NEURON-1:0]   w_masked;
  logic [PW-1:0]           w_padded;
  logic [OUT_WIDTH-1:0]    w_rd_data;

  assign w_acc       = in_valid & in_ready;
  assign w_op        = in_data[FP_DATA_WIDTH-1 -: 2];
  assign w_load_last = (r_word_cnt + WW'(1)) == {r_active, 2'b00};
  assign w_spk_hit   = spike_valid && (spike_val != '0)
                       && ({1'b0, spike_id} < r_active);

  // Bits at or beyond the active count never leak into readout words.
  for (genvar g = 0; g < NUM_NEURON; g++) begin : g_mask
    assign w_masked[g] = r_states[g] & (AW'(g) < r_active);
  end

  assign w_padded  = PW'(w_masked);
  assign w_rd_data = OUT_WIDTH'(w_padded >> (32'(r_rd_idx) * 32'(OUT_WIDTH)));
  assign w_rd_end  = (32'(r_rd_idx) + 32'd1) * 32'(OUT_WIDTH);
  assign w_rd_last = w_rd_end >= 32'(r_active);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (w_op)
            2'b01: w_next = S_LOAD;
            2'b10: begin
              if (in_data[RW-1:0] == '0) begin
                w_next = S_READ;
                w_done = 1'b1;
              end else begin
                w_next = S_RUN;
              end
            end
            2'b11: w_next = S_READ;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: if (w_acc && w_load_last) w_next = S_IDLE;
      S_RUN: begin
        if (r_run_left == RW'(1)) begin
          w_next = S_READ;
          w_done = 1'b1;
        end
      end
      S_READ: if (out_ready && w_rd_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_active   <= AW'(NUM_NEURON);
      r_states   <= '1;
      r_word_cnt <= '0;
      r_run_left <= '0;
      r_rd_idx   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_field <= '0;
      r_wr_idx   <= '0;
      r_wr_data  <= '0;
      r_run_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_run_done <= w_done;
      r_wr_en    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_rd_idx <= '0;
          if (w_acc) begin
            unique case (w_op)
              2'b00: r_active <= {1'b0, in_data[NEURON_ID_WIDTH-1:0]} + AW'(1);
              2'b01: begin
                r_states   <= '1;
                r_word_cnt <= '0;
              end
              2'b10: r_run_left <= in_data[RW-1:0];
              default: r_rd_idx <= '0;
            endcase
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_wr_en    <= 1'b1;
            r_wr_idx   <= r_word_cnt[NEURON_ID_WIDTH+1:2];
            r_wr_field <= r_word_cnt[1:0];
            r_wr_data  <= in_data;
            r_word_cnt <= r_word_cnt + WW'(1);
          end
        end
        S_RUN: begin
          r_run_left <= r_run_left - RW'(1);
          if (w_spk_hit) r_states[spike_id] <= ~r_states[spike_id];
        end
        S_READ: if (out_ready) r_rd_idx <= r_rd_idx + AW'(1);
        default: r_rd_idx <= '0;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy         = r_state != S_IDLE;
  assign arr_run      = r_state == S_RUN;
  assign out_valid    = r_state == S_READ;
  assign out_data     = out_valid ? w_rd_data : '0;
  assign arr_wr_en    = r_wr_en;
  assign arr_wr_field = r_wr_field;
  assign arr_wr_idx   = r_wr_idx;
  assign arr_wr_data  = r_wr_data;
  assign run_done     = r_run_done;

endmodule

// File: tb/tb_neuron_array_seq.sv
// Randomised bench for neuron_array_seq against a bit-array model
// of the neuron states, active count and write sequence.
module tb_neuron_array_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        arr_wr_en;
  logic [1:0]  arr_wr_field;
  logic [8:0]  arr_wr_idx;
  logic [15:0] arr_wr_data;
  logic        arr_run;
  logic        spike_valid;
  logic [8:0]  spike_id;
  logic [1:0]  spike_val;
  logic        busy;
  logic        run_done;

  neuron_array_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .arr_wr_en(arr_wr_en), .arr_wr_field(arr_wr_field),
    .arr_wr_idx(arr_wr_idx), .arr_wr_data(arr_wr_data),
    .arr_run(arr_run), .spike_valid(spike_valid),
    .spike_id(spike_id), .spike_val(spike_val),
    .busy(busy), .run_done(run_done)
  );

  always #5 clk = ~clk;

  logic [26:0] wlog [0:8191];
  int wn = 0;
  int run_cyc = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (arr_wr_en && wn < 8192) begin
      wlog[wn] <= {arr_wr_idx, arr_wr_field, arr_wr_data};
      wn <= wn + 1;
    end
    if (arr_run) run_cyc <= run_cyc + 1;
    if (run_done) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int m_act;
  bit m_st [0:511];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 512;
    for (int i = 0; i < 512; i++) m_st[i] = 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_act(input int a);
    send(16'(a - 1), 0);
    m_act = a;
  endtask

  task automatic do_load(input bit seq);
    int base;
    int nw;
    logic [15:0] dat [0:2047];
    base = wn;
    nw = 4 * m_act;
    send(16'h4000, 0);
    for (int i = 0; i < 512; i++) m_st[i] = 1'b1;
    for (int i = 0; i < nw; i++) begin
      dat[i] = seq ? 16'(16'h100 + i) : 16'($urandom);
      send(dat[i], ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("wr_count", 64'(wn - base), 64'(nw));
    for (int i = 0; i < nw; i++)
      chk("wr_strobe", wlog[base + i], {9'(i >> 2), 2'(i & 3), dat[i]});
    chk("load_idle", busy, 0);
  endtask

  task automatic do_read(input int stall_word, input int stall_len);
    int nw;
    int t;
    logic [15:0] e;
    nw = (m_act + 15) / 16;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("rd_valid", out_valid, 1);
      e = '0;
      for (int j = 0; j < 16; j++)
        if (k * 16 + j < m_act) e[j] = m_st[k * 16 + j];
      chk("rd_word", out_data, e);
      if (k == stall_word) begin
        repeat (stall_len) begin
          @(negedge clk);
          chk("rd_hold", out_data, e);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    chk("rd_idle", busy, 0);
    chk("rd_ovalid_off", out_valid, 0);
  endtask

  task automatic do_run(input int n, input bit fixed, input int stall);
    int rc0;
    int dc0;
    bit       fv [0:4];
    int       fi [0:4];
    int       fval [0:4];
    fv = '{1, 1, 1, 1, 0};
    fi = '{2, 2, 1, 7, 0};
    fval = '{1, 2, 0, 1, 0};
    rc0 = run_cyc;
    dc0 = done_cnt;
    spike_valid = 1'b1;
    spike_id    = 9'd0;
    spike_val   = 2'd1;
    send(16'h8000 | 16'(n), 0);
    for (int c = 0; c < n; c++) begin
      if (fixed && c < 5) begin
        spike_valid = fv[c];
        spike_id    = 9'(fi[c]);
        spike_val   = 2'(fval[c]);
      end else begin
        spike_valid = 1'($urandom_range(0, 1));
        spike_id    = 9'($urandom_range(0, (m_act + 4 > 511) ? 511 : m_act + 4));
        spike_val   = 2'($urandom_range(0, 3));
      end
      if (spike_valid && spike_val != 0 && int'(spike_id) < m_act)
        m_st[spike_id] = ~m_st[spike_id];
      @(posedge clk);
      #1;
    end
    spike_valid = 1'b1;
    spike_id    = 9'd0;
    spike_val   = 2'd1;
    do_read(0, stall);
    spike_valid = 1'b0;
    chk("run_cycles", 64'(run_cyc - rc0), 64'(n));
    chk("run_done_cnt", 64'(done_cnt - dc0), 1);
  endtask

  task automatic pulse_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    spike_valid = 1'b0;
    spike_id = '0;
    spike_val = '0;
    pulse_reset(3);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_run", arr_run, 0);
    chk("rst_wr", arr_wr_en, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_done", run_done, 0);

    set_act(4);
    do_load(1'b1);

    do_run(5, 1'b1, 0);

    set_act(40);
    send(16'hC000, 0);
    do_read(1, 4);

    do_run(0, 1'b0, 0);

    set_act(7);
    send(16'h4000, 0);
    for (int i = 0; i < 5; i++) send(16'(16'h200 + i), 0);
    pulse_reset(1);
    @(negedge clk);
    chk("midload_wr", arr_wr_en, 0);
    chk("midload_busy", busy, 0);
    set_act(1);
    do_load(1'b0);

    set_act(512);
    send(16'hC000, 0);
    do_read(31, 2);

    for (int it = 0; it < 14; it++) begin
      set_act($urandom_range(1, 48));
      if ($urandom_range(0, 2) == 0) do_load(1'b0);
      do_run($urandom_range(0, 12), 1'b0, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        send(16'hC000, 0);
        do_read(0, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
